// File: rtl/rc_pwm_decoder.sv
`default_nettype none
// ============================================================================
// Module      : rc_pwm_decoder
// Description : Measures the high-phase width of an RC receiver PWM signal in
//               microseconds, range-checks it, and flags loss of signal.
//               Optional 4-clock persistence glitch filter after the
//               synchronizer, enabled by defining RC_PWM_GLITCH_FILTER_EN.
// Ports       : clk             system clock
//               rst_n           asynchronous active-low reset
//               i_rc_in         raw PWM line (asynchronous to clk)
//               o_width_us      last accepted pulse width, microseconds
//               o_pulse_valid   1-cycle strobe, o_width_us just updated
//               o_range_err     1-cycle strobe, pulse outside MIN_US..MAX_US
//               o_signal_lost   level, no accepted pulse within TIMEOUT_MS
// Revision    : 1.0 - initial release
// ============================================================================
module rc_pwm_decoder #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned MIN_US     = 800,
  parameter int unsigned MAX_US     = 2200,
  parameter int unsigned TIMEOUT_MS = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rc_in,
  output logic [11:0] o_width_us,
  output logic        o_pulse_valid,
  output logic        o_range_err,
  output logic        o_signal_lost
);

  localparam int unsigned     C_DIV       = CLK_HZ / 1000000;
  localparam int unsigned     C_PW        = (C_DIV > 1) ? $clog2(C_DIV) : 1;
  localparam logic [C_PW-1:0] C_PRESC_MAX = C_PW'(C_DIV - 1);
  localparam int unsigned     C_TW        = (TIMEOUT_MS > 0) ? $clog2(TIMEOUT_MS + 1) : 1;
  localparam logic [C_TW-1:0] C_TO_MAX    = C_TW'(TIMEOUT_MS);
  localparam logic [11:0]     C_MIN       = 12'(MIN_US);
  localparam logic [11:0]     C_MAX       = 12'(MAX_US);
  localparam logic [11:0]     C_SAT       = 12'hFFF;

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sync1;
  logic             r_sync2;
  logic             w_level;
  logic             r_prev;
  logic             w_rise;
  logic             w_fall;
  logic [3:0]       r_settle;
  logic [C_PW-1:0]  r_presc;
  logic             w_us_tick;
  logic [11:0]      r_cnt;
  logic [11:0]      w_cnt_inc;
  logic             w_done;
  logic             w_in_range;
  logic             w_accept;
  logic [9:0]       r_us_cnt;
  logic             w_ms_tick;
  logic [C_TW-1:0]  r_to_cnt;
  logic [11:0]      r_width;
  logic             r_valid;
  logic             r_err;
  logic             r_lost;

  // Two-flop synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_rc_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef RC_PWM_GLITCH_FILTER_EN
  // Persistence filter: the level follows the input only after four
  // consecutive samples that disagree with the current filtered level.
  logic       r_filt;
  logic [1:0] r_filt_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt     <= 1'b0;
      r_filt_cnt <= 2'd0;
    end else if (r_sync2 == r_filt) begin
      r_filt_cnt <= 2'd0;
    end else if (r_filt_cnt == 2'd3) begin
      r_filt     <= r_sync2;
      r_filt_cnt <= 2'd0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 2'd1;
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync2;
`endif

  // Edge detection against one further register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= w_level;
  end

  assign w_rise = w_level & ~r_prev;
  assign w_fall = ~w_level & r_prev;

  // The reset values of the input pipeline look like a quiet low line. ARM
  // waits until the pipeline holds real samples before trusting a low level,
  // so a pulse already in progress at reset release is never measured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_settle <= 4'd0;
    else if (r_state == ST_ARM && r_settle != 4'hF) r_settle <= r_settle + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_ARM;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARM:  if (r_settle == 4'hF && !w_level) w_state_nxt = ST_LOW;
      ST_LOW:  if (w_rise) w_state_nxt = ST_HIGH;
      ST_HIGH: if (w_fall) w_state_nxt = ST_LOW;
      default: w_state_nxt = ST_ARM;
    endcase
  end

  // 1 us prescaler, phase-aligned to each rising edge.
  assign w_us_tick = (r_presc == C_PRESC_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_presc <= '0;
    else if (w_rise || w_us_tick) r_presc <= '0;
    else                       r_presc <= r_presc + C_PW'(1);
  end

  // Saturating pulse counter. The tick landing in the falling-edge cycle is
  // included so the width equals floor(high_clocks / C_DIV).
  assign w_cnt_inc = (w_us_tick && r_cnt != C_SAT) ? r_cnt + 12'd1 : r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          r_cnt <= 12'd0;
    else if (r_state != ST_HIGH && w_state_nxt == ST_HIGH) r_cnt <= 12'd0;
    else if (r_state == ST_HIGH)                         r_cnt <= w_cnt_inc;
  end

  assign w_done     = (r_state == ST_HIGH) && w_fall;
  // A saturated count is always a failure, even if MAX_US reaches 4095.
  assign w_in_range = (w_cnt_inc >= C_MIN) && (w_cnt_inc <= C_MAX) && (w_cnt_inc != C_SAT);
  assign w_accept   = w_done && w_in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_width <= 12'd0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_accept;
      r_err   <= w_done && !w_in_range;
      if (w_accept) r_width <= w_cnt_inc;
    end
  end

  // Millisecond divider and loss-of-signal timeout; both restart on every
  // accepted pulse so the timeout is measured from that strobe.
  assign w_ms_tick = w_us_tick && (r_us_cnt == 10'd999);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_us_cnt <= 10'd0;
      r_to_cnt <= '0;
      r_lost   <= 1'b1;
    end else if (w_accept) begin
      r_us_cnt <= 10'd0;
      r_to_cnt <= '0;
      r_lost   <= 1'b0;
    end else begin
      if (w_ms_tick)       r_us_cnt <= 10'd0;
      else if (w_us_tick)  r_us_cnt <= r_us_cnt + 10'd1;
      if (w_ms_tick && r_to_cnt != C_TO_MAX) r_to_cnt <= r_to_cnt + C_TW'(1);
      if (r_to_cnt == C_TO_MAX) r_lost <= 1'b1;
    end
  end

  assign o_width_us    = r_width;
  assign o_pulse_valid = r_valid;
  assign o_range_err   = r_err;
  assign o_signal_lost = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_rc_pwm_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rc_pwm_decoder
// Description : Self-checking bench for rc_pwm_decoder (2 MHz clock model,
//               3 ms timeout) using a vector table plus directed sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rc_pwm_decoder;

  localparam int CLK_HZ     = 2000000;
  localparam int DIV        = 2;
  localparam int TIMEOUT_MS = 3;
  localparam int GAP_US     = 100;
`ifdef RC_PWM_GLITCH_FILTER_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        rc_in = 1'b0;
  logic [11:0] width_us;
  logic        pulse_valid;
  logic        range_err;
  logic        signal_lost;

  rc_pwm_decoder #(
    .CLK_HZ    (CLK_HZ),
    .MIN_US    (800),
    .MAX_US    (2200),
    .TIMEOUT_MS(TIMEOUT_MS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rc_in      (rc_in),
    .o_width_us   (width_us),
    .o_pulse_valid(pulse_valid),
    .o_range_err  (range_err),
    .o_signal_lost(signal_lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  int n_valid = 0, n_err = 0;
  int strobe_cyc = 0, valid_cyc = 0, fall_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  // Strobe monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pulse_valid) begin
        n_valid++;
        valid_cyc  = cyc;
        strobe_cyc = cyc;
        chk("lost_clear_on_valid", int'(signal_lost), 0);
      end
      if (range_err) begin
        n_err++;
        strobe_cyc = cyc;
      end
      if (pulse_valid || range_err)
        chk("strobe_exclusive", int'(pulse_valid & range_err), 0);
    end
  end

  task automatic hold(input logic v, input int n);
    @(posedge clk);
    #1;
    rc_in = v;
    if (!v) fall_cyc = cyc;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic pulse(input int us);
    hold(1'b1, us * DIV);
    hold(1'b0, GAP_US * DIV);
    @(negedge clk);
  endtask

  typedef struct {
    int us;
    int valid;
    int width;
    int lost;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int v0, e0, k;

    vecs[0]  = '{1500, 1, 1500, 0};
    vecs[1]  = '{1000, 1, 1000, 0};
    vecs[2]  = '{2000, 1, 2000, 0};
    vecs[3]  = '{1000, 1, 1000, 0};
    vecs[4]  = '{2000, 1, 2000, 0};
    vecs[5]  = '{ 500, 0, 2000, 0};
    vecs[6]  = '{2500, 0, 2000, 1};  // 3.3 ms since last accept
    vecs[7]  = '{ 800, 1,  800, 0};
    vecs[8]  = '{ 799, 0,  800, 0};
    vecs[9]  = '{2200, 1, 2200, 0};
    vecs[10] = '{2201, 0, 2200, 0};
    vecs[11] = '{4100, 0, 2200, 1};  // saturates the counter

    // Reset state, with the line already high.
    rst_n = 1'b0;
    rc_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_width", int'(width_us), 0);
    chk("rst_valid", int'(pulse_valid), 0);
    chk("rst_err",   int'(range_err), 0);
    chk("rst_lost",  int'(signal_lost), 1);

    // Partial pulse in progress at release must be discarded.
    @(posedge clk);
    #1 rst_n = 1'b1;
    hold(1'b1, 1000 * DIV);
    hold(1'b0, GAP_US * DIV);
    @(negedge clk);
    chk("partial_valid", n_valid, 0);
    chk("partial_err",   n_err, 0);
    chk("partial_lost",  int'(signal_lost), 1);

    for (int i = 0; i < 12; i++) begin
      v0 = n_valid;
      e0 = n_err;
      pulse(vecs[i].us);
      chk($sformatf("v%0d_%0dus_valid", i, vecs[i].us), n_valid - v0, vecs[i].valid);
      chk($sformatf("v%0d_%0dus_err",   i, vecs[i].us), n_err - e0, 1 - vecs[i].valid);
      chk($sformatf("v%0d_%0dus_width", i, vecs[i].us), int'(width_us), vecs[i].width);
      chk($sformatf("v%0d_%0dus_lost",  i, vecs[i].us), int'(signal_lost), vecs[i].lost);
      chk($sformatf("v%0d_%0dus_latency", i, vecs[i].us), strobe_cyc - fall_cyc, LAT);
    end

    // Timeout: recover, go quiet, and time the loss flag.
    v0 = n_valid;
    pulse(1200);
    chk("recover_valid", n_valid - v0, 1);
    chk("recover_width", int'(width_us), 1200);
    chk("recover_lost",  int'(signal_lost), 0);
    hold(1'b0, 2800 * DIV);
    @(negedge clk);
    chk("lost_before_timeout", int'(signal_lost), 0);
    k = 0;
    while (!signal_lost && k < 4 * 1000 * DIV) begin
      @(negedge clk);
      k++;
    end
    chk("lost_after_timeout", int'(signal_lost), 1);
    if (signal_lost)
      chk_range("timeout_cycles", cyc - valid_cyc,
                TIMEOUT_MS * 1000 * DIV, (TIMEOUT_MS + 1) * 1000 * DIV);

    // 2-clock low glitch in the middle of a 1500 us pulse.
    v0 = n_valid;
    e0 = n_err;
    hold(1'b1, 1499);
    hold(1'b0, 2);
    hold(1'b1, 1499);
    hold(1'b0, GAP_US * DIV);
    @(negedge clk);
`ifdef RC_PWM_GLITCH_FILTER_EN
    chk("glitch_valid", n_valid - v0, 1);
    chk("glitch_err",   n_err - e0, 0);
    chk("glitch_width", int'(width_us), 1500);
`else
    chk("glitch_valid", n_valid - v0, 0);
    chk("glitch_err_seen", int'((n_err - e0) >= 1), 1);
    chk("glitch_width", int'(width_us), 1200);
`endif

    v0 = n_valid;
    pulse(1500);
    chk("pre_reset_valid", n_valid - v0, 1);
    chk("pre_reset_width", int'(width_us), 1500);
    chk("pre_reset_lost",  int'(signal_lost), 0);

    // Reset asserted mid-pulse takes effect without a clock edge.
    hold(1'b1, 600);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_width", int'(width_us), 0);
    chk("midrst_valid", int'(pulse_valid), 0);
    chk("midrst_err",   int'(range_err), 0);
    chk("midrst_lost",  int'(signal_lost), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    v0 = n_valid;
    e0 = n_err;
    hold(1'b1, 400);
    hold(1'b0, GAP_US * DIV);
    @(negedge clk);
    chk("midrst_tail_valid", n_valid - v0, 0);
    chk("midrst_tail_err",   n_err - e0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
